// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Stall / flush / bubble controller for a 5-stage pipeline with a multi-cycle
//   multiply/divide unit. A two-state FSM (IDLE, MD_WAIT) launches mult/div
//   operations, holds the front of the pipeline while the unit works, and
//   abandons the operation after MD_TIMEOUT wait cycles. In IDLE it also turns
//   taken branches into F/D flushes and RAW hazards into front-end stalls.
//
//   Optional feature: define STALL_CNT_EN to build a saturating counter of
//   cycles with stall_pc=1. Without it stall_cycles is tied to zero.
//
// Parameters
//   MD_TIMEOUT : maximum number of MD_WAIT cycles before abandoning (>=1)
//   CNT_W      : width of stall_cycles
// Ports
//   clock             in  : single clock, rising edge
//   reset_n           in  : asynchronous active-low reset
//   dx_insn[31:0]     in  : instruction in D/X (opcode [31:27], ALU op [6:2])
//   data_hazard       in  : RAW hazard flag from the hazard detector
//   branch_taken      in  : taken branch/jump resolved in X this cycle
//   multdiv_ready     in  : mult/div result valid this cycle
//   multdiv_exception in  : mult/div exception, qualified by multdiv_ready
//   cnt_clr           in  : synchronous clear of stall_cycles
//   ctrl_mult/div     out : one-cycle start pulses to the mult/div unit
//   stall_pc/fd/dx    out : hold PC, F/D latch, D/X latch
//   bubble_dx/xm      out : load a nop into D/X, X/M
//   flush_fd          out : load a nop into F/D
//   md_done/exc/timeout out : one-cycle completion / exception / timeout pulses
//   stall_cycles      out : stall performance counter (registered)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      dx_insn,
  input  logic             data_hazard,
  input  logic             branch_taken,
  input  logic             multdiv_ready,
  input  logic             multdiv_exception,
  input  logic             cnt_clr,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             flush_fd,
  output logic             md_done,
  output logic             md_exc,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // Wait counter only needs to reach MD_TIMEOUT-1.
  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;

  // Instruction decode
  logic dx_is_mult, dx_is_div, md_start, wait_expired;

  assign dx_is_mult   = (dx_insn[31:27] == 5'b00000) && (dx_insn[6:2] == 5'b00110);
  assign dx_is_div    = (dx_insn[31:27] == 5'b00000) && (dx_insn[6:2] == 5'b00111);
  assign md_start     = dx_is_mult || dx_is_div;
  assign wait_expired = (wait_cnt_reg == WAIT_W'(MD_TIMEOUT - 1));

  // Only the opcode and ALU-op fields matter here.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{dx_insn[26:7], dx_insn[1:0]};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        // A taken branch squashes the instruction in D/X, so no start.
        if (!branch_taken && md_start) begin
          state_next    = MD_WAIT;
          wait_cnt_next = '0;
        end
      end
      MD_WAIT: begin
        // Ready wins over expiry when both land in the same cycle.
        if (multdiv_ready || wait_expired) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    stall_pc   = 1'b0;
    stall_fd   = 1'b0;
    stall_dx   = 1'b0;
    bubble_dx  = 1'b0;
    bubble_xm  = 1'b0;
    flush_fd   = 1'b0;
    md_done    = 1'b0;
    md_exc     = 1'b0;
    md_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (branch_taken) begin
          flush_fd  = 1'b1;
          bubble_dx = 1'b1;
        end else if (md_start) begin
          ctrl_mult = dx_is_mult;
          ctrl_div  = dx_is_div;
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
        end else if (data_hazard) begin
          // D/X keeps flowing; the bubble replaces the dependent instruction.
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      MD_WAIT: begin
        if (multdiv_ready) begin
          md_done = 1'b1;
          md_exc  = multdiv_exception;
        end else if (wait_expired) begin
          md_timeout = 1'b1;
        end else begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef STALL_CNT_EN
  // Saturating count of PC-stall cycles; clear has priority over increment.
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= '0;
    end else if (stall_pc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_cycles   = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed testbench for pipeline_stall_ctrl (MD_TIMEOUT=8, CNT_W=4).
//   Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
//   later, well away from the next edge. The eleven one-bit control outputs are
//   compared as one packed vector against hand-written constants.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {ctrl_mult, ctrl_div, stall_pc, stall_fd, stall_dx,
  //  bubble_dx, bubble_xm, flush_fd, md_done, md_exc, md_timeout}
  localparam logic [10:0] O_NONE    = 11'b000_0000_0000;
  localparam logic [10:0] O_MULT    = 11'b101_1101_0000;
  localparam logic [10:0] O_DIV     = 11'b011_1101_0000;
  localparam logic [10:0] O_WAIT    = 11'b001_1101_0000;
  localparam logic [10:0] O_DONE    = 11'b000_0000_0100;
  localparam logic [10:0] O_DONEX   = 11'b000_0000_0110;
  localparam logic [10:0] O_TMO     = 11'b000_0000_0001;
  localparam logic [10:0] O_BRANCH  = 11'b000_0010_1000;
  localparam logic [10:0] O_HAZARD  = 11'b001_1010_0000;

  localparam logic [31:0] INSN_MULT = 32'h0000_0018; // opcode 0, ALU op 00110
  localparam logic [31:0] INSN_DIV  = 32'h0000_001C; // opcode 0, ALU op 00111
  localparam logic [31:0] INSN_ADD  = 32'h0000_0000;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [31:0]      dx_insn;
  logic             data_hazard, branch_taken, multdiv_ready, multdiv_exception, cnt_clr;
  logic             ctrl_mult, ctrl_div, stall_pc, stall_fd, stall_dx;
  logic             bubble_dx, bubble_xm, flush_fd, md_done, md_exc, md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [10:0]      outs;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_cnt   = 0;

  always #5 clock = ~clock;

  pipeline_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .dx_insn(dx_insn),
    .data_hazard(data_hazard), .branch_taken(branch_taken),
    .multdiv_ready(multdiv_ready), .multdiv_exception(multdiv_exception),
    .cnt_clr(cnt_clr), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
    .md_done(md_done), .md_exc(md_exc), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles)
  );

  assign outs = {ctrl_mult, ctrl_div, stall_pc, stall_fd, stall_dx,
                 bubble_dx, bubble_xm, flush_fd, md_done, md_exc, md_timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational outputs and the counter, clock once,
  // then advance the counter model from the expected stall_pc.
  task automatic step(input string tag, input logic [10:0] exp);
    #1;
    chk(tag, {21'b0, outs}, {21'b0, exp});
    chk({tag, "_cnt"}, {28'b0, stall_cycles}, CNT_EN ? exp_cnt : 0);
    $display("step %-12s outs=%011b stall_cycles=%0d", tag, outs, stall_cycles);
    @(posedge clock);
    if (cnt_clr)                      exp_cnt = 0;
    else if (exp[8] && exp_cnt != 15) exp_cnt = exp_cnt + 1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; dx_insn = INSN_ADD; data_hazard = 1'b0; branch_taken = 1'b0;
    multdiv_ready = 1'b0; multdiv_exception = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("reset_outs", {21'b0, outs}, {21'b0, O_NONE});
    chk("reset_cnt",  {28'b0, stall_cycles}, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    step("idle", O_NONE);

    // Multiply, ready arrives on cycle 5; branch/hazard ignored while waiting
    dx_insn = INSN_MULT; step("mult_c0", O_MULT);
    dx_insn = INSN_ADD;  step("mult_c1", O_WAIT);
    branch_taken = 1'b1; data_hazard = 1'b1; step("mult_c2_ign", O_WAIT);
    branch_taken = 1'b0; data_hazard = 1'b0; step("mult_c3", O_WAIT);
    step("mult_c4", O_WAIT);
    multdiv_ready = 1'b1; step("mult_c5_done", O_DONE);
    multdiv_ready = 1'b0; data_hazard = 1'b1; step("mult_c6_idle", O_HAZARD);
    data_hazard = 1'b0;

    // Divide with exception on cycle 3
    dx_insn = INSN_DIV; step("div_c0", O_DIV);
    dx_insn = INSN_ADD; step("div_c1", O_WAIT);
    step("div_c2", O_WAIT);
    multdiv_ready = 1'b1; multdiv_exception = 1'b1; step("div_c3_exc", O_DONEX);
    multdiv_ready = 1'b0; multdiv_exception = 1'b0; step("div_c4", O_NONE);

    // Divide that never completes: timeout on cycle 8, late ready ignored
    dx_insn = INSN_DIV; step("tmo_c0", O_DIV);
    dx_insn = INSN_ADD;
    for (int i = 1; i < MD_TIMEOUT; i++) step($sformatf("tmo_c%0d", i), O_WAIT);
    step("tmo_c8", O_TMO);
    multdiv_ready = 1'b1; step("tmo_late_rdy", O_NONE);
    multdiv_ready = 1'b0; step("tmo_idle", O_NONE);

    // Priority: branch > mult start > hazard
    dx_insn = INSN_MULT; branch_taken = 1'b1; data_hazard = 1'b1;
    step("prio_branch", O_BRANCH);
    branch_taken = 1'b0; step("prio_mult", O_MULT);
    dx_insn = INSN_ADD; step("prio_wait", O_WAIT);
    multdiv_ready = 1'b1; step("prio_done", O_DONE);
    multdiv_ready = 1'b0; step("prio_hazard", O_HAZARD);

    // Saturating stall counter, then clear while stalled
    for (int i = 0; i < 20; i++) step($sformatf("cnt_hz%0d", i), O_HAZARD);
    cnt_clr = 1'b1; step("cnt_clr", O_HAZARD);
    cnt_clr = 1'b0; data_hazard = 1'b0; step("cnt_after_clr", O_NONE);

    // Reset in the middle of MD_WAIT
    dx_insn = INSN_DIV; step("rst_c0", O_DIV);
    dx_insn = INSN_ADD; step("rst_c1", O_WAIT);
    multdiv_ready = 1'b0;
    #1;
    chk("rst_pre_wait", {21'b0, outs}, {21'b0, O_WAIT});
    #2 reset_n = 1'b0;
    multdiv_ready = 1'b1;
    #1;
    chk("rst_async_outs", {21'b0, outs}, {21'b0, O_NONE});
    chk("rst_async_cnt",  {28'b0, stall_cycles}, 32'd0);
    exp_cnt = 0;
    @(posedge clock); #1;
    chk("rst_no_done", {21'b0, outs}, {21'b0, O_NONE});
    #2 reset_n = 1'b1;
    multdiv_ready = 1'b0;
    @(posedge clock); #1;
    step("rst_rel_idle", O_NONE);
    data_hazard = 1'b1; step("rst_rel_hz", O_HAZARD);
    data_hazard = 1'b0; step("rst_rel_end", O_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
